// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and divider state encoding shared by ALU control and the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_DIVU = 4'b0011;
    localparam logic [3:0] ALU_MFHI = 4'b0100;
    localparam logic [3:0] ALU_MFLO = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divu_hilo_unit_if.sv
// divu_hilo_unit_if: EX-stage connection between the pipeline and the HI/LO divider.
interface divu_hilo_unit_if #(parameter int WIDTH = 32);

    logic [3:0]       alu_op;
    logic             ex_valid;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall;
    logic             div_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_result;

    modport master (
        output alu_op, ex_valid, flush, dividend, divisor,
        input  stall, div_done, hi, lo, mf_result
    );

    modport slave (
        input  alu_op, ex_valid, flush, dividend, divisor,
        output stall, div_done, hi, lo, mf_result
    );

endinterface

// File: rtl/divu_step.sv
// divu_step: one combinational restoring-division step on a {rem,quo} pair.
module divu_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    logic           ge;

    assign sh   = {rem, quo[WIDTH-1]};
    assign diff = sh - {1'b0, divisor};
    // rem < divisor keeps sh < 2*divisor, so the borrow bit alone decides sh >= divisor
    assign ge    = ~diff[WIDTH];
    assign rem_n = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit: multi-cycle unsigned divider owning HI/LO, stalling EX while busy.
module divu_hilo_unit
    import alu_pkg::*;
#(parameter int WIDTH = 32) (
    input logic             clk,
    input logic             rst_n,
    divu_hilo_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state, state_n;
    logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n, hi, lo;
    logic [CW-1:0]    cnt;
    logic             start, zdiv, last;

    assign start = (state == IDLE) && bus.ex_valid && !bus.flush && (bus.alu_op == ALU_DIVU);
    assign zdiv  = (bus.divisor == '0);
    assign last  = (cnt == LAST);

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .quo    (quo),
        .divisor(dvs),
        .rem_n  (rem_n),
        .quo_n  (quo_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (start ? (zdiv ? DONE : BUSY) : IDLE) :
                  state == BUSY ? (bus.flush ? IDLE : (last ? DONE : BUSY)) :
                  IDLE;
    end

    // A flush on the final BUSY cycle still wins, so HI/LO are never half-committed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else if (start) begin
            rem <= '0;
            quo <= bus.dividend;
            dvs <= bus.divisor;
            cnt <= '0;
            if (zdiv) begin
                hi <= bus.dividend;
                lo <= '1;
            end
        end else if (state == BUSY && !bus.flush) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                hi <= rem_n;
                lo <= quo_n;
            end
        end
    end

    always_comb begin
        bus.stall     = start || (state == BUSY);
        bus.div_done  = (state == DONE);
        bus.hi        = hi;
        bus.lo        = lo;
        bus.mf_result = bus.alu_op == ALU_MFHI ? hi :
                        bus.alu_op == ALU_MFLO ? lo : '0;
    end

endmodule
